md_unit: RTL
============

// Module: md_unit
// PURPOSE
// - Multiply/divide unit in the E stage, beside the ALU; owns the HI/LO registers.
// - Runs mult/multu/div/divu over a fixed multi-cycle latency.
// - Serves mfhi/mflo reads and mthi/mtlo writes.
// - Drives md_busy to the hazard control unit, which stalls D while an md-class instruction waits.
// PARAMETERS
// - MULT_CYCLES  5   cycles busy after a mult/multu start (>=1)
// - DIV_CYCLES   10  cycles busy after a div/divu start (>=1)
// PORTS
// - clk       in   1   single clock, rising edge
// - reset     in   1   asynchronous, active-low; 0 clears all state immediately
// - md_op     in   4   E-stage md operation (encoding in package); MD_NONE for bubbles
// - rs_val    in   32  forwarded rs operand (post-FwdALUA mux)
// - rt_val    in   32  forwarded rt operand (post-FwdALUB mux)
// - md_start  out  1   combinational: md_op is MULT/MULTU/DIV/DIVU and unit not busy
// - md_busy   out  1   registered: an operation is in flight
// - md_rdata  out  32  combinational: HI if MFHI, LO if MFLO, else 0
// - hi_q      out  32  architectural HI (debug/trace)
// - lo_q      out  32  architectural LO (debug/trace)
// BEHAVIOUR
// - Reset: hi_q=lo_q=0, md_busy=0, counter=0, pending results=0. Asserting reset mid-operation aborts it; no HI/LO commit.
// - States:
//   - IDLE: md_busy=0.
//   - RUN: md_busy=1, counter counting down.
// - IDLE -> RUN on an edge with md_start=1:
//   - Latch the full result into pend_hi/pend_lo.
//   - counter <= MULT_CYCLES or DIV_CYCLES.
// - RUN: counter decrements each edge. On the edge where counter==1:
//   - hi_q<=pend_hi, lo_q<=pend_lo, md_busy<=0, go to IDLE.
//   - A start issued at cycle t therefore commits at edge t+N; results are readable from cycle t+N.
// - Arithmetic:
//   - MULT: {hi,lo} = $signed(rs)*$signed(rt), 64-bit.
//   - MULTU: {hi,lo} = unsigned 64-bit product.
//   - DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
//     - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//   - DIVU: unsigned quotient/remainder.
//   - rt==0 for DIV/DIVU: the operation still runs the full busy period, then leaves HI/LO unchanged (no commit).
// - MTHI/MTLO: write rs_val into hi_q/lo_q at the next edge, only when md_busy=0; ignored while busy.
// - MFHI/MFLO:
//   - md_rdata reflects current hi_q/lo_q with no bypass of a same-edge mthi/mtlo.
//   - The HCU guarantees no read while busy.
// - Start while busy:
//   - md_start is forced 0 and the op is ignored.
//   - Protocol violation: the bench asserts that it never occurs, because the HCU stalls D while (md_start|md_busy) and D holds an md-class op.
// - HCU stall term, computed in HCU, not here: stall_md = D_is_md && (md_start || md_busy).
// - No flush input. E-stage bubbles present MD_NONE, so an in-flight op is never cancelled except by reset.
// STRUCTURE
// - Shared package md_pkg:
//   - MD_OP_W=4.
//   - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
//   - Function is_md_start(op). The D-stage decoder and the HCU import the same constants.
// - One natural sub-module, md_calc:
//   - Purely combinational result compute (64-bit product, signed/unsigned div/rem, div-by-zero flag).
// - md_unit itself holds the counter, FSM, pend_* regs and HI/LO.
// TESTING
// - MULT 0xFFFFFFFE*0x00000003 -> md_busy high 5 cycles; then hi_q=0xFFFFFFFF, lo_q=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
// - DIV -7/2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
// - DIVU 5/0 with HI=0x11, LO=0x22 preloaded by MTHI/MTLO -> busy 10 cycles; HI/LO stay 0x11/0x22.
// - MULT start, MFLO presented 2 cycles later -> md_start=0, md_busy=1, HCU stall=1 until the commit edge; the MFLO after the stall returns the product low word.
// - Reset low in cycle 3 of a DIV -> md_busy=0 and hi_q=lo_q=0 immediately; after release no commit occurs.
// - MTHI 0xDEADBEEF then MFHI the next cycle -> md_rdata=0xDEADBEEF, md_busy stays 0.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared multiply/divide operation encoding and helpers.
//                The D-stage decoder, HCU and md_unit all use these constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam int MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

    // True for the operations that occupy the unit for a multi-cycle period
    function automatic logic is_md_start(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the divide flavours (longer latency, divide-by-zero possible)
    function automatic logic is_md_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
//  Module      : md_calc
//  Description : Combinational result generator for mult/multu/div/divu.
//                Produces the full {hi,lo} result and a divide-by-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_calc
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [31:0]        i_rs_val,
    input  logic [31:0]        i_rt_val,
    output logic [31:0]        o_res_hi,
    output logic [31:0]        o_res_lo,
    output logic               o_div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_rt_zero;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    // Products: sign-extending to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the signed product.
    assign w_prod_u = {32'd0, i_rs_val} * {32'd0, i_rt_val};
    assign w_prod_s = {{32{i_rs_val[31]}}, i_rs_val} * {{32{i_rt_val[31]}}, i_rt_val};

    // Divide on magnitudes, then restore signs. DIVU never negates, so one
    // unsigned divider serves both flavours. The 0x80000000 / -1 case falls
    // out naturally: magnitude 0x80000000, negated back to 0x80000000.
    assign w_rt_zero    = (i_rt_val == 32'd0);
    assign w_signed_div = (i_op == MD_DIV);
    assign w_neg_a      = w_signed_div & i_rs_val[31];
    assign w_neg_b      = w_signed_div & i_rt_val[31];
    assign w_mag_a      = w_neg_a ? (32'd0 - i_rs_val) : i_rs_val;
    assign w_mag_b      = w_neg_b ? (32'd0 - i_rt_val) : i_rt_val;
    // A zero divisor is replaced so the divider output is always defined;
    // the result is discarded via o_div_by_zero anyway.
    assign w_div_b      = w_rt_zero ? 32'd1 : w_mag_b;
    assign w_uq         = w_mag_a / w_div_b;
    assign w_ur         = w_mag_a % w_div_b;
    assign w_q          = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r          = w_neg_a ? (32'd0 - w_ur) : w_ur;

    // Select the result pair for the requested operation
    always_comb begin
        o_res_hi      = 32'd0;
        o_res_lo      = 32'd0;
        o_div_by_zero = is_md_div(i_op) && w_rt_zero;
        case (i_op)
            MD_MULT: begin
                o_res_hi = w_prod_s[63:32];
                o_res_lo = w_prod_s[31:0];
            end
            MD_MULTU: begin
                o_res_hi = w_prod_u[63:32];
                o_res_lo = w_prod_u[31:0];
            end
            MD_DIV, MD_DIVU: begin
                o_res_hi = w_r;
                o_res_lo = w_q;
            end
            default: begin
                o_res_hi = 32'd0;
                o_res_lo = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : E-stage multiply/divide unit owning HI/LO. Runs mult/div
//                over a fixed latency, serves mfhi/mflo and mthi/mtlo, and
//                reports md_busy to the hazard control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    output logic               md_start,
    output logic               md_busy,
    output logic [31:0]        md_rdata,
    output logic [31:0]        hi_q,
    output logic [31:0]        lo_q
);

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_commit;
    logic               w_start;
    logic               w_idle;

    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_ok;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_div_by_zero;

    md_calc u_calc (
        .i_op          (md_op),
        .i_rs_val      (rs_val),
        .i_rt_val      (rt_val),
        .o_res_hi      (w_res_hi),
        .o_res_lo      (w_res_lo),
        .o_div_by_zero (w_div_by_zero)
    );

    assign w_idle   = (r_state == c_S_IDLE);
    assign w_start  = is_md_start(md_op) && w_idle;
    assign md_start = w_start;
    assign md_busy  = (r_state == c_S_RUN);
    assign hi_q     = r_hi;
    assign lo_q     = r_lo;

    // State and countdown register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= c_CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: load the latency on start, count down, commit when it reaches 1
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_S_RUN;
                    w_cnt_nxt   = is_md_div(md_op) ? c_DIV_LOAD : c_MULT_LOAD;
                end
            end
            c_S_RUN: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_commit    = 1'b1;
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    // Pending result capture and HI/LO update (commit or mthi/mtlo when idle)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_ok <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            if (w_start) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                // A divide by zero still spends its busy period but never commits
                r_pend_ok <= !w_div_by_zero;
            end
            if (w_commit && r_pend_ok) begin
                r_hi <= r_pend_hi;
            end else if (w_idle && (md_op == MD_MTHI)) begin
                r_hi <= rs_val;
            end
            if (w_commit && r_pend_ok) begin
                r_lo <= r_pend_lo;
            end else if (w_idle && (md_op == MD_MTLO)) begin
                r_lo <= rs_val;
            end
        end
    end

    // Read port: current architectural HI/LO, no same-edge bypass
    always_comb begin
        md_rdata = 32'd0;
        if (md_op == MD_MFHI) begin
            md_rdata = r_hi;
        end else if (md_op == MD_MFLO) begin
            md_rdata = r_lo;
        end
    end

endmodule
`default_nettype wire
